// File: rtl/arashi_thread_fifo.sv
// arashi_thread_fifo: synchronous single-clock FIFO with registered read data.
// DEPTH entries, all usable; pointers carry one extra wrap bit so that full and
// empty are distinguished without a separate counter register.
// Optional error flags (ovf_err/udf_err) are compiled only when the macro
// ARASHI_THREAD_FIFO_ERR_EN is defined; otherwise those ports and their logic
// are absent and every other behaviour is unchanged.
module arashi_thread_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_LVL  = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    w_ena,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_ena,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    out_vld,
  output logic                    avail,
  output logic                    full,
  output logic                    afull,
`ifdef ARASHI_THREAD_FIFO_ERR_EN
  output logic                    ovf_err,
  output logic                    udf_err,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         occ;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_drop;
  logic                  rd_drop;

  // Occupancy flags and accept/drop decisions, derived from registered pointers only
  always_comb begin
    occ     = w_ptr - r_ptr;
    avail   = 1'b0;
    full    = 1'b0;
    afull   = 1'b0;
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    wr_drop = 1'b0;
    rd_drop = 1'b0;
    avail   = (occ != PW'(0));
    full    = (occ == PW'(DEPTH));
    afull   = (occ >= PW'(AFULL_LVL));
    // A read only issues from a non-empty FIFO, so an empty FIFO never falls through.
    rd_acc  = r_ena && avail;
    // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
    wr_acc  = w_ena && (!full || rd_acc);
    wr_drop = w_ena && !wr_acc;
    rd_drop = r_ena && !avail;
  end

  assign count = occ;

  // Pointer update; the wrap bit rolls naturally modulo 2*DEPTH
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + PW'(1);
      if (rd_acc) r_ptr <= r_ptr + PW'(1);
    end
  end

  // Storage array; cleared on reset so stale entries can never resurface
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc) begin
      mem[w_ptr[AW-1:0]] <= data_in;
    end
  end

  // Registered read port; data_out holds its value when no read is accepted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_out <= '0;
      out_vld  <= 1'b0;
    end else begin
      out_vld <= rd_acc;
      if (rd_acc) data_out <= mem[r_ptr[AW-1:0]];
    end
  end

`ifdef ARASHI_THREAD_FIFO_ERR_EN
  // Sticky overflow/underflow flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_drop) ovf_err <= 1'b1;
      if (rd_drop) udf_err <= 1'b1;
    end
  end
`else
  // Drop indications only feed the optional error flags
  logic unused_drop;
  assign unused_drop = wr_drop ^ rd_drop;
`endif

endmodule

// File: tb/tb_arashi_thread_fifo.sv
// Directed testbench for arashi_thread_fifo (DATA_WIDTH=32, DEPTH=8).
// Error-flag checks are included when ARASHI_THREAD_FIFO_ERR_EN is defined.
module tb_arashi_thread_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          rstn;
  logic          w_ena;
  logic [DW-1:0] data_in;
  logic          r_ena;
  logic [DW-1:0] data_out;
  logic          out_vld;
  logic          avail;
  logic          full;
  logic          afull;
  logic [3:0]    count;
`ifdef ARASHI_THREAD_FIFO_ERR_EN
  logic          ovf_err;
  logic          udf_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  arashi_thread_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .w_ena    (w_ena),
    .data_in  (data_in),
    .r_ena    (r_ena),
    .data_out (data_out),
    .out_vld  (out_vld),
    .avail    (avail),
    .full     (full),
    .afull    (afull),
`ifdef ARASHI_THREAD_FIFO_ERR_EN
    .ovf_err  (ovf_err),
    .udf_err  (udf_err),
`endif
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_ena = 1'b0;
    r_ena = 1'b0;
    data_in = '0;
  endtask

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ev;

  initial begin
    rstn = 1'b0;
    idle();
    step();
    step();
    rstn = 1'b1;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_avail", 64'(avail), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_afull", 64'(afull), 64'd0);
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_dout", 64'(data_out), 64'd0);
`ifdef ARASHI_THREAD_FIFO_ERR_EN
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_udf", 64'(udf_err), 64'd0);
`endif

    // Read from empty FIFO is ignored
    r_ena = 1'b1;
    step();
    idle();
    chk("empty_rd_vld", 64'(out_vld), 64'd0);
    chk("empty_rd_count", 64'(count), 64'd0);
`ifdef ARASHI_THREAD_FIFO_ERR_EN
    chk("empty_rd_udf", 64'(udf_err), 64'd1);
`endif

    // Fill with 0x11..0x88; afull from count 6
    for (int i = 0; i < 8; i++) begin
      w_ena = 1'b1;
      data_in = DW'((i + 1) * 'h11);
      step();
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_afull", 64'(afull), 64'((i + 1) >= 6));
    end
    chk("fill_full", 64'(full), 64'd1);

    // Ninth write is dropped
    data_in = 32'h99;
    step();
    idle();
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_full", 64'(full), 64'd1);
`ifdef ARASHI_THREAD_FIFO_ERR_EN
    chk("ovf_flag", 64'(ovf_err), 64'd1);
`endif

    // Drain: data emerges in order, one cycle after each read edge
    for (int i = 0; i < 8; i++) begin
      r_ena = 1'b1;
      step();
      chk("drain_vld", 64'(out_vld), 64'd1);
      chk("drain_data", 64'(data_out), 64'((i + 1) * 'h11));
      chk("drain_count", 64'(count), 64'(7 - i));
    end
    idle();
    chk("drain_avail", 64'(avail), 64'd0);
    step();
    chk("hold_vld", 64'(out_vld), 64'd0);
    chk("hold_data", 64'(data_out), 64'h88);

    // Refill across the pointer wrap, then simultaneous read/write while full
    for (int i = 0; i < 8; i++) begin
      w_ena = 1'b1;
      data_in = DW'((i + 1) * 'h11);
      step();
    end
    chk("refill_full", 64'(full), 64'd1);
    w_ena = 1'b1;
    r_ena = 1'b1;
    data_in = 32'hAA;
    step();
    idle();
    chk("rw_full_count", 64'(count), 64'd8);
    chk("rw_full_vld", 64'(out_vld), 64'd1);
    chk("rw_full_data", 64'(data_out), 64'h11);
    for (int i = 0; i < 8; i++) begin
      r_ena = 1'b1;
      step();
      ev = (i == 7) ? 32'hAA : DW'((i + 2) * 'h11);
      chk("rw_drain_data", 64'(data_out), 64'(ev));
      chk("rw_drain_vld", 64'(out_vld), 64'd1);
    end
    idle();
    chk("rw_drain_avail", 64'(avail), 64'd0);

    // Streaming at occupancy 1 over many pointer wraps
    w_ena = 1'b1;
    data_in = 32'h01;
    step();
    exp_q.push_back(32'h01);
    for (int i = 0; i < 20; i++) begin
      w_ena = 1'b1;
      r_ena = 1'b1;
      data_in = DW'(32'h100 + i);
      step();
      exp_q.push_back(DW'(32'h100 + i));
      ev = exp_q.pop_front();
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_vld", 64'(out_vld), 64'd1);
      chk("stream_data", 64'(data_out), 64'(ev));
    end
    idle();

    // Reset in the middle of operation with five entries stored
    for (int i = 0; i < 4; i++) begin
      w_ena = 1'b1;
      data_in = DW'(32'h200 + i);
      step();
    end
    r_ena = 1'b1;
    w_ena = 1'b0;
    step();
    w_ena = 1'b1;
    r_ena = 1'b0;
    data_in = 32'h300;
    step();
    chk("pre_rst_count", 64'(count), 64'd5);
    w_ena = 1'b1;
    r_ena = 1'b1;
    rstn = 1'b0;
    step();
    idle();
    rstn = 1'b1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_avail", 64'(avail), 64'd0);
    chk("mid_rst_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_data", 64'(data_out), 64'd0);
`ifdef ARASHI_THREAD_FIFO_ERR_EN
    chk("mid_rst_ovf", 64'(ovf_err), 64'd0);
    chk("mid_rst_udf", 64'(udf_err), 64'd0);
`endif

    // Entries stored before reset are gone: a read now is ignored
    r_ena = 1'b1;
    step();
    idle();
    chk("post_rst_vld", 64'(out_vld), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arashi_thread_fifo.md
ARASHI_THREAD_FIFO -- requirements
Module: arashi_thread_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, 8, number of entries; power of two, >=2.
REQ-003 SHALL have parameter AFULL_LVL, DEPTH-2, occupancy at or above which afull asserts (1..DEPTH).
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port w_ena  input  1  write request.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  write payload.
REQ-008 SHALL have port r_ena  input  1  read request.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  registered read payload.
REQ-010 SHALL have port out_vld  output  1  data_out holds a newly read entry this cycle.
REQ-011 SHALL have port avail  output  1  occupancy non-zero.
REQ-012 SHALL have port full  output  1  occupancy equals DEPTH.
REQ-013 SHALL have port afull  output  1  occupancy >= AFULL_LVL.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL store up to DEPTH entries (all slots usable); pointers $clog2(DEPTH)+1 bits, MSB as wrap bit.
REQ-016 SHALL accept a write when w_ena=1 and (full=0 or a read is accepted the same cycle); entry stored at w_ptr, w_ptr increments.
REQ-017 SHALL accept a read when r_ena=1 and avail=1; data_out <= entry at r_ptr, r_ptr increments.
REQ-018 SHALL present read data one cycle after the accepting edge: out_vld=1 for exactly that cycle, 0 otherwise.
REQ-019 SHALL hold data_out unchanged on cycles with no accepted read.
REQ-020 SHALL drop writes when full=1 with no accepted read: no state change.
REQ-021 SHALL ignore reads when avail=0: no pointer change, out_vld=0 next cycle.
REQ-022 SHALL, on simultaneous accepted read and write, keep count unchanged; when empty, the read is rejected and only the write takes effect (no fall-through).
REQ-023 SHALL wrap pointers modulo 2*DEPTH with no loss of ordering; strict FIFO order.
REQ-024 SHALL derive count, avail, full, afull combinationally from registered pointers only.

Reset
REQ-025 SHALL, with rstn=0 at posedge, clear w_ptr, r_ptr, data_out, out_vld, and all storage to 0; count=0, avail=0, full=0, afull=0 next cycle.
REQ-026 SHALL give reset priority over w_ena/r_ena; mid-operation reset discards all stored entries.

Configuration
REQ-027 SHALL compile an error-flag feature only when macro ARASHI_THREAD_FIFO_ERR_EN is defined.
REQ-028 SHALL, with ARASHI_THREAD_FIFO_ERR_EN defined, add outputs ovf_err (1) and udf_err (1): sticky-set the cycle after a dropped write (REQ-020) or ignored read (REQ-021), cleared only by reset.
REQ-029 SHALL, without ARASHI_THREAD_FIFO_ERR_EN, omit ovf_err/udf_err ports and logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: DATA_WIDTH=32, DEPTH=8, reset then read with empty FIFO -> out_vld=0, count=0, udf_err=1 (ERR_EN).
REQ-031 SHALL cover: write 0x11..0x88 over 8 cycles -> full=1, count=8, afull=1 from count 6; 9th write 0x99 dropped, ovf_err=1.
REQ-032 SHALL cover: from full, 8 reads -> data_out 0x11..0x88 in order, each one cycle after its read, avail=0 after last.
REQ-033 SHALL cover: full FIFO, simultaneous w_ena(0xAA)/r_ena -> count stays 8, 0xAA emerges as 8th subsequent read.
REQ-034 SHALL cover: 20 interleaved write/read cycles at count 1 -> pointer wrap, data order preserved, count constant 1.
REQ-035 SHALL cover: reset asserted with count=5 -> next cycle count=0, avail=0, out_vld=0, data_out=0, error flags 0.
